tm1637_frame_ctrl: RTL

- Sequences one complete TM1637 display refresh over the DIO-mode byte transmitter: START, command bytes, four segment bytes, STOP, and the brightness/display-control command.
- Latches hex digits, decimal points, blanking and brightness on an update request.
- Encodes digits to 7-segment and issues ordered operations to the transmitter through a req/done handshake.
- Retries the whole frame on NACK or timeout; sits between user logic and the transmitter in the LED_TM1637 top level.

---
 rtl/tm1637_frame_ctrl_if.sv | 29 ++
 rtl/tm1637_frame_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1637_frame_ctrl_if.sv
// Operation handshake between the TM1637 frame controller and the DIO-mode
// byte transmitter. The controller is the master: it presents an operation
// with a one-cycle request, and the transmitter answers with busy/done/nack.
interface tm1637_frame_ctrl_if;
   logic [1:0] eng_op;
   logic [7:0] eng_data;
   logic       eng_req;
   logic       eng_busy;
   logic       eng_done;
   logic       eng_nack;

   modport master (
      output eng_op,
      output eng_data,
      output eng_req,
      input  eng_busy,
      input  eng_done,
      input  eng_nack
   );

   modport slave (
      input  eng_op,
      input  eng_data,
      input  eng_req,
      output eng_busy,
      output eng_done,
      output eng_nack
   );
endinterface

// File: rtl/tm1637_frame_ctrl.sv
// TM1637 frame controller: latches a display image on request, encodes the
// hex digits to 7-segment bytes and walks the transmitter through one full
// refresh (data command, addressed segment write, display control). A NACK
// or a stalled operation aborts the frame with a STOP and retries it from
// the beginning until the retry budget is spent.
module tm1637_frame_ctrl #(
   parameter int unsigned MAX_RETRY      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       update,
   input  logic [15:0]                digits,
   input  logic [3:0]                 dp,
   input  logic [3:0]                 blank,
   input  logic [2:0]                 brightness,
   input  logic                       display_on,
   tm1637_frame_ctrl_if.master        eng,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [2:0]                 retries
);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_BYTE  = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;

   localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
   // The counter is cleared on issue, so the last legal value is one short
   // of the limit; the next idle WAIT cycle is the fault.
   localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] LAST_STEP   = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ISSUE       = 3'd1,
      ST_WAIT        = 3'd2,
      ST_ABORT_ISSUE = 3'd3,
      ST_ABORT_WAIT  = 3'd4,
      ST_FINISH      = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [2:0]  retry_q, retry_d;
   logic [9:0]  tmo_q, tmo_d;

   logic        pending_q, pending_d;
   logic [15:0] pend_digits_q, pend_digits_d;
   logic [3:0]  pend_dp_q, pend_dp_d;
   logic [3:0]  pend_blank_q, pend_blank_d;
   logic [2:0]  pend_bri_q, pend_bri_d;
   logic        pend_on_q, pend_on_d;

   logic [15:0] lat_digits_q, lat_digits_d;
   logic [3:0]  lat_dp_q, lat_dp_d;
   logic [3:0]  lat_blank_q, lat_blank_d;
   logic [2:0]  lat_bri_q, lat_bri_d;
   logic        lat_on_q, lat_on_d;

   logic [1:0]  eng_op_q, eng_op_d;
   logic [7:0]  eng_data_q, eng_data_d;
   logic        eng_req_q, eng_req_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [2:0]  retries_q, retries_d;

   logic [7:0]  seg_s [4];
   logic [7:0]  ctrl_s;
   logic [1:0]  step_op_s;
   logic [7:0]  step_data_s;

   // Hex digit to segments a..g (bit0 = a, bit6 = g).
   function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
      logic [6:0] code;
      case (d)
         4'h0:    code = 7'h3F;
         4'h1:    code = 7'h06;
         4'h2:    code = 7'h5B;
         4'h3:    code = 7'h4F;
         4'h4:    code = 7'h66;
         4'h5:    code = 7'h6D;
         4'h6:    code = 7'h7D;
         4'h7:    code = 7'h07;
         4'h8:    code = 7'h7F;
         4'h9:    code = 7'h6F;
         4'hA:    code = 7'h77;
         4'hB:    code = 7'h7C;
         4'hC:    code = 7'h39;
         4'hD:    code = 7'h5E;
         4'hE:    code = 7'h79;
         4'hF:    code = 7'h71;
         default: code = 7'h00;
      endcase
      return code;
   endfunction

   // Operation type of each frame step: three START..STOP transactions.
   function automatic logic [1:0] op_of_step(input logic [3:0] s);
      logic [1:0] op;
      case (s)
         4'd0, 4'd3, 4'd10: op = OP_START;
         4'd2, 4'd9, 4'd12: op = OP_STOP;
         default:           op = OP_BYTE;
      endcase
      return op;
   endfunction

   // Segment bytes and display-control byte from the latched image.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (lat_blank_q[i]) begin
            seg_s[i] = 8'h00;
         end else begin
            seg_s[i] = {lat_dp_q[i], hex_to_seg(lat_digits_q[4*i +: 4])};
         end
      end
      if (lat_on_q) begin
         ctrl_s = {5'b10001, lat_bri_q};
      end else begin
         ctrl_s = 8'h80;
      end
   end

   // Operation and payload for the current step (payload is zero for START/STOP).
   always_comb begin
      step_op_s = op_of_step(step_q);
      case (step_q)
         4'd1:    step_data_s = 8'h40;
         4'd4:    step_data_s = 8'hC0;
         4'd5:    step_data_s = seg_s[0];
         4'd6:    step_data_s = seg_s[1];
         4'd7:    step_data_s = seg_s[2];
         4'd8:    step_data_s = seg_s[3];
         4'd11:   step_data_s = ctrl_s;
         default: step_data_s = 8'h00;
      endcase
   end

   // Frame sequencer: next state, step/retry/timeout bookkeeping and outputs.
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      retry_d       = retry_q;
      tmo_d         = tmo_q;
      pending_d     = pending_q;
      pend_digits_d = pend_digits_q;
      pend_dp_d     = pend_dp_q;
      pend_blank_d  = pend_blank_q;
      pend_bri_d    = pend_bri_q;
      pend_on_d     = pend_on_q;
      lat_digits_d  = lat_digits_q;
      lat_dp_d      = lat_dp_q;
      lat_blank_d   = lat_blank_q;
      lat_bri_d     = lat_bri_q;
      lat_on_d      = lat_on_q;
      eng_op_d      = eng_op_q;
      eng_data_d    = eng_data_q;
      eng_req_d     = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_d         = err_q;
      retries_d     = retries_q;

      // A request that arrives while a frame is running (including its
      // FINISH cycle) is parked in the shadow registers; newest wins.
      if (update && (state_q != ST_IDLE)) begin
         pending_d     = 1'b1;
         pend_digits_d = digits;
         pend_dp_d     = dp;
         pend_blank_d  = blank;
         pend_bri_d    = brightness;
         pend_on_d     = display_on;
      end else begin
         pending_d     = pending_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (update || pending_q) begin
               if (update) begin
                  lat_digits_d = digits;
                  lat_dp_d     = dp;
                  lat_blank_d  = blank;
                  lat_bri_d    = brightness;
                  lat_on_d     = display_on;
               end else begin
                  lat_digits_d = pend_digits_q;
                  lat_dp_d     = pend_dp_q;
                  lat_blank_d  = pend_blank_q;
                  lat_bri_d    = pend_bri_q;
                  lat_on_d     = pend_on_q;
               end
               pending_d = 1'b0;
               err_d     = 1'b0;
               retry_d   = 3'd0;
               busy_d    = 1'b1;
               step_d    = 4'd0;
               state_d   = ST_ISSUE;
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            if (!eng.eng_busy) begin
               eng_req_d  = 1'b1;
               eng_op_d   = step_op_s;
               eng_data_d = step_data_s;
               tmo_d      = 10'd0;
               state_d    = ST_WAIT;
            end else begin
               state_d    = ST_ISSUE;
            end
         end

         ST_WAIT: begin
            if (eng.eng_done) begin
               if ((eng_op_q == OP_BYTE) && eng.eng_nack) begin
                  if (retry_q < RETRY_LIMIT) begin
                     retry_d = retry_q + 3'd1;
                  end else begin
                     err_d   = 1'b1;
                  end
                  state_d = ST_ABORT_ISSUE;
               end else if (step_q == LAST_STEP) begin
                  state_d = ST_FINISH;
               end else begin
                  step_d  = step_q + 4'd1;
                  state_d = ST_ISSUE;
               end
            end else if (tmo_q == TMO_LAST) begin
               if (retry_q < RETRY_LIMIT) begin
                  retry_d = retry_q + 3'd1;
               end else begin
                  err_d   = 1'b1;
               end
               state_d = ST_ABORT_ISSUE;
            end else begin
               tmo_d   = tmo_q + 10'd1;
            end
         end

         ST_ABORT_ISSUE: begin
            if (!eng.eng_busy) begin
               eng_req_d  = 1'b1;
               eng_op_d   = OP_STOP;
               eng_data_d = 8'h00;
               tmo_d      = 10'd0;
               state_d    = ST_ABORT_WAIT;
            end else begin
               state_d    = ST_ABORT_ISSUE;
            end
         end

         ST_ABORT_WAIT: begin
            // Whatever the abort STOP reports, the frame moves on.
            if (eng.eng_done || (tmo_q == TMO_LAST)) begin
               if (err_q) begin
                  state_d = ST_FINISH;
               end else begin
                  step_d  = 4'd0;
                  state_d = ST_ISSUE;
               end
            end else begin
               tmo_d = tmo_q + 10'd1;
            end
         end

         ST_FINISH: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            retries_d = retry_q;
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset; reset abandons any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         step_q        <= 4'd0;
         retry_q       <= 3'd0;
         tmo_q         <= 10'd0;
         pending_q     <= 1'b0;
         pend_digits_q <= 16'h0000;
         pend_dp_q     <= 4'h0;
         pend_blank_q  <= 4'h0;
         pend_bri_q    <= 3'd0;
         pend_on_q     <= 1'b0;
         lat_digits_q  <= 16'h0000;
         lat_dp_q      <= 4'h0;
         lat_blank_q   <= 4'h0;
         lat_bri_q     <= 3'd0;
         lat_on_q      <= 1'b0;
         eng_op_q      <= 2'b00;
         eng_data_q    <= 8'h00;
         eng_req_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         retries_q     <= 3'd0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         retry_q       <= retry_d;
         tmo_q         <= tmo_d;
         pending_q     <= pending_d;
         pend_digits_q <= pend_digits_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         pend_bri_q    <= pend_bri_d;
         pend_on_q     <= pend_on_d;
         lat_digits_q  <= lat_digits_d;
         lat_dp_q      <= lat_dp_d;
         lat_blank_q   <= lat_blank_d;
         lat_bri_q     <= lat_bri_d;
         lat_on_q      <= lat_on_d;
         eng_op_q      <= eng_op_d;
         eng_data_q    <= eng_data_d;
         eng_req_q     <= eng_req_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         retries_q     <= retries_d;
      end
   end

   assign eng.eng_op   = eng_op_q;
   assign eng.eng_data = eng_data_q;
   assign eng.eng_req  = eng_req_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign retries      = retries_q;

endmodule
